// File: rtl/microwave_ctrl.sv
// Cooking-cycle controller: drives one-cycle set/reset pulses into the magnetron
// SR latch and runs a BCD mm:ss countdown gated by start, stop/clear and door.
module microwave_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  output logic        latch_s,
  output logic        latch_r,
  output logic        mag_on,
  output logic [15:0] time_out,
  output logic [1:0]  state_o,
  output logic        done
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          latch_s_q, latch_s_d;
  logic          latch_r_q, latch_r_d;
  logic          mag_on_q, mag_on_d;
  logic          done_q, done_d;
  logic [15:0]   dec_time;

  // Saturate each digit to the largest value legal in its position.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (mt > 4'd9) mt = 4'd9;
    if (mu > 4'd9) mu = 4'd9;
    if (st > 4'd5) st = 4'd5;
    if (su > 4'd9) su = 4'd9;
    return {mt, mu, st, su};
  endfunction

  // mm:ss decrement by one second; only ever applied to a non-zero time.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign dec_time = bcd_dec(time_q);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    tick_d    = tick_q;
    latch_s_d = 1'b0;
    latch_r_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (stop_clear) begin
          time_d = 16'h0000;
        end else if (load) begin
          time_d = bcd_clamp(time_in);
        end else if (start && door_closed && (time_q != 16'h0000)) begin
          state_d   = COOK;
          latch_s_d = 1'b1;
          tick_d    = '0;
        end
      end

      COOK: begin
        // Door/stop wins over a coincident terminal tick; time and tick freeze.
        if (!door_closed || stop_clear) begin
          state_d   = PAUSE;
          latch_r_d = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          time_d = dec_time;
          if (dec_time == 16'h0000) begin
            state_d   = DONE;
            latch_r_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      PAUSE: begin
        if (stop_clear) begin
          state_d = IDLE;
          time_d  = 16'h0000;
        end else if (start && door_closed) begin
          state_d   = COOK;
          latch_s_d = 1'b1;
        end
      end

      DONE: begin
        time_d = 16'h0000;
        if (start || stop_clear || !door_closed) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        latch_r_d = 1'b1;
      end
    endcase

    mag_on_d = (state_d == COOK);
    done_d   = (state_d == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      time_q    <= 16'h0000;
      tick_q    <= '0;
      latch_s_q <= 1'b0;
      latch_r_q <= 1'b1;
      mag_on_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      tick_q    <= tick_d;
      latch_s_q <= latch_s_d;
      latch_r_q <= latch_r_d;
      mag_on_q  <= mag_on_d;
      done_q    <= done_d;
    end
  end

  assign latch_s  = latch_s_q;
  assign latch_r  = latch_r_q;
  assign mag_on   = mag_on_q;
  assign time_out = time_q;
  assign state_o  = state_q;
  assign done     = done_q;

endmodule
